// File: rtl/spread_frame_ctrl.sv
`timescale 1ns/1ps
// spread_frame_ctrl: frame sequencer in front of the DSSS spreader.
// On start it sends a fixed preamble (MSB first), then len_q payload bits
// passed through from upstream. It then waits SPREAD cycles for the last bit's
// chips to drain and pulses o_done for one cycle.
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_start, i_len         frame request and payload bit count (IDLE only)
//   i_abort                abandon current frame (PRE/PAY/DRAIN)
//   o_busy, o_done         status: busy outside IDLE, one-cycle done pulse
//   i_pay_data/valid,
//   o_pay_ready            upstream payload bit handshake
//   o_spr_data/valid,
//   i_spr_ready            spreader input handshake
module spread_frame_ctrl #(
  parameter int unsigned SPREAD       = 24,
  parameter int unsigned PREAMBLE_LEN = 16,
  parameter logic [31:0] PREAMBLE     = 32'h0000_A5F0,
  parameter int unsigned LEN_W        = 12
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  input  logic             i_pay_data,
  input  logic             i_pay_valid,
  output logic             o_pay_ready,
  output logic             o_spr_data,
  output logic             o_spr_valid,
  input  logic             i_spr_ready
);

  localparam int unsigned PRE_CW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam int unsigned CNT_W  = (LEN_W > PRE_CW) ? LEN_W : PRE_CW;
  localparam int unsigned DRN_W  = (SPREAD > 0) ? $clog2(SPREAD + 1) : 1;
  localparam int unsigned IDX_W  = 5;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(SPREAD - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_PAY   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DRN_W-1:0]  drn_cnt_q;
  logic              busy_q;
  logic              done_q;

  logic              spr_xfer;
  logic [CNT_W-1:0]  pay_last;
  logic [IDX_W-1:0]  pre_idx;

  assign spr_xfer = o_spr_valid & i_spr_ready;
  // len_q is never zero while in PAY, so the subtraction cannot underflow there.
  assign pay_last = CNT_W'(len_q) - CNT_W'(1);
  assign pre_idx  = IDX_W'(PREAMBLE_LEN - 1) - IDX_W'(bit_cnt_q);

  assign o_busy = busy_q;
  assign o_done = done_q;

  // Spreader/upstream handshake decode; PAY is a pure pass-through.
  always_comb begin
    o_spr_valid = 1'b0;
    o_spr_data  = 1'b0;
    o_pay_ready = 1'b0;
    case (state_q)
      ST_PRE: begin
        o_spr_valid = 1'b1;
        o_spr_data  = PREAMBLE[pre_idx];
      end
      ST_PAY: begin
        o_spr_valid = i_pay_valid;
        o_spr_data  = i_pay_data;
        o_pay_ready = i_spr_ready;
      end
      default: begin
        o_spr_valid = 1'b0;
        o_spr_data  = 1'b0;
        o_pay_ready = 1'b0;
      end
    endcase
  end

  // Frame sequencer: state, counters and registered status outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      bit_cnt_q <= '0;
      drn_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q   <= ST_PRE;
            len_q     <= i_len;
            bit_cnt_q <= '0;
            drn_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_PRE: begin
          if (i_abort) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else if (spr_xfer) begin
            if (bit_cnt_q == PRE_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= (len_q != '0) ? ST_PAY : ST_DRAIN;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_PAY: begin
          if (i_abort) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else if (spr_xfer) begin
            if (bit_cnt_q == pay_last) begin
              bit_cnt_q <= '0;
              state_q   <= ST_DRAIN;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Counts the SPREAD cycles following the last transfer.
          if (i_abort) begin
            state_q   <= ST_IDLE;
            drn_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else if (drn_cnt_q == DRN_LAST) begin
            state_q   <= ST_DONE;
            drn_cnt_q <= '0;
            done_q    <= 1'b1;
          end else begin
            drn_cnt_q <= drn_cnt_q + DRN_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spread_frame_ctrl.sv
`timescale 1ns/1ps
// Testbench for spread_frame_ctrl: directed frames plus randomized payloads
// and spreader back-pressure, checked against a frame-level expectation model
// (preamble bits followed by payload bits, SPREAD-cycle drain, single done).
module tb_spread_frame_ctrl;

  localparam int unsigned SPREAD = 24;
  localparam int unsigned PLEN   = 16;
  localparam int unsigned LEN_W  = 12;
  localparam logic [31:0] PRE_PAT = 32'h0000_A5F0;

  logic             i_clk;
  logic             i_reset;
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             i_abort;
  logic             o_busy;
  logic             o_done;
  logic             i_pay_data;
  logic             i_pay_valid;
  logic             o_pay_ready;
  logic             o_spr_data;
  logic             o_spr_valid;
  logic             i_spr_ready;

  spread_frame_ctrl #(
    .SPREAD      (SPREAD),
    .PREAMBLE_LEN(PLEN),
    .PREAMBLE    (PRE_PAT),
    .LEN_W       (LEN_W)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_len      (i_len),
    .i_abort    (i_abort),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .i_pay_data (i_pay_data),
    .i_pay_valid(i_pay_valid),
    .o_pay_ready(o_pay_ready),
    .o_spr_data (o_spr_data),
    .o_spr_valid(o_spr_valid),
    .i_spr_ready(i_spr_ready)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Frame context, written only by the main sequence.
  int   frame_id   = 0;
  int   pay_start  = 0;
  int   pay_len    = 0;
  int   ready_mode = 0;
  int   stall_at   = -1;
  int   stall_len  = 0;
  logic pay_bits [0:4095];

  // Written only by the driver.
  int   pay_total = 0;
  logic stalling  = 1'b0;

  // Written only by the monitor.
  int   cyc = 0;
  logic got_q[$];
  int   got_pay, done_cnt, last_xfer_cyc, stab_viol, stall_viol;
  logic saw_pay_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Upstream source and spreader ready generator, updated on negedges.
  initial begin
    int rc, seen, sdone, idx;
    rc = 0; seen = -1; sdone = 0;
    i_spr_ready = 1'b0; i_pay_valid = 1'b0; i_pay_data = 1'b0;
    forever begin
      @(posedge i_clk);
      if (!i_reset && i_pay_valid && o_pay_ready) pay_total++;
      @(negedge i_clk);
      if (frame_id != seen) begin
        seen  = frame_id;
        sdone = 0;
        rc    = 0;
      end
      case (ready_mode)
        1: begin
          i_spr_ready = (rc == 0);
          rc = (rc == 24) ? 0 : rc + 1;
        end
        2:       i_spr_ready = 1'($urandom_range(0, 1));
        default: i_spr_ready = 1'b1;
      endcase
      idx = pay_total - pay_start;
      stalling = 1'b0;
      if (idx == stall_at && sdone < stall_len) begin
        i_pay_valid = 1'b0;
        stalling    = 1'b1;
        sdone++;
      end else if (idx < pay_len) begin
        i_pay_valid = 1'b1;
        i_pay_data  = pay_bits[idx];
      end else begin
        i_pay_valid = 1'b0;
      end
    end
  end

  // Transfer recorder; sees pre-edge values at each rising edge.
  initial begin
    int   mon_frame;
    logic pv, pr, pd;
    mon_frame = -1; pv = 1'b0; pr = 1'b0; pd = 1'b0;
    forever begin
      @(posedge i_clk);
      cyc++;
      if (frame_id != mon_frame) begin
        mon_frame = frame_id;
        got_q.delete();
        got_pay = 0; done_cnt = 0; last_xfer_cyc = 0;
        stab_viol = 0; stall_viol = 0; saw_pay_ready = 1'b0;
      end
      if (i_reset) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr && !(o_spr_valid === 1'b1 && o_spr_data === pd)) stab_viol++;
        if (o_spr_valid && i_spr_ready) begin
          got_q.push_back(o_spr_data);
          last_xfer_cyc = cyc;
        end
        if (i_pay_valid && o_pay_ready) got_pay++;
        if (o_pay_ready) saw_pay_ready = 1'b1;
        if (o_done) done_cnt++;
        if (stalling && o_spr_valid) stall_viol++;
        pv = o_spr_valid; pr = i_spr_ready; pd = o_spr_data;
      end
    end
  end

  // Runs one frame starting at a negedge and checks it against the model.
  task automatic run_frame(input int len, input int mode, input int st_at, input int st_len,
                           input int abort_at, input int extra_at, input bit rnd, input string tag);
    int          k, idx, budget, done_k, gap, exp_n, mism;
    bit          aborted, got_done;
    logic        exp_q[$];
    logic [31:0] pv;
    pv = PRE_PAT;
    if (rnd) for (int i = 0; i < len; i++) pay_bits[i] = 1'($urandom_range(0, 1));
    ready_mode = mode; stall_at = st_at; stall_len = st_len;
    pay_len = len; pay_start = pay_total; frame_id++;
    for (int i = 0; i < PLEN; i++) exp_q.push_back(pv[PLEN-1-i]);
    for (int i = 0; i < len; i++) exp_q.push_back(pay_bits[i]);
    i_start = 1'b1;
    i_len   = LEN_W'(len);
    budget  = 40 * (PLEN + len) + 200;
    k = 0; aborted = 1'b0; got_done = 1'b0; done_k = 0; gap = 0;
    while (k < budget) begin
      @(negedge i_clk);
      k++;
      i_start = (k == extra_at);
      if (k == extra_at) i_len = LEN_W'(7);
      i_abort = 1'b0;
      if (aborted) break;
      if (o_done) begin
        got_done = 1'b1;
        done_k   = k;
        gap      = cyc - last_xfer_cyc;
        check({tag, "_busy_in_done"}, 32'(o_busy), 32'd1);
        @(negedge i_clk);
        check({tag, "_busy_after_done"}, 32'(o_busy), 32'd0);
        check({tag, "_done_one_cycle"}, 32'(o_done), 32'd0);
        break;
      end
      idx = pay_total - pay_start;
      if (abort_at >= 0 && idx == abort_at) begin
        i_abort = 1'b1;
        aborted = 1'b1;
      end
    end
    i_start = 1'b0;
    if (!got_done && !aborted) check({tag, "_frame_timeout"}, 32'd0, 32'd1);
    if (aborted) begin
      check({tag, "_abort_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_abort_valid"}, 32'(o_spr_valid), 32'd0);
      check({tag, "_abort_pay_ready"}, 32'(o_pay_ready), 32'd0);
    end
    exp_n = aborted ? PLEN + abort_at + 1 : PLEN + len;
    check({tag, "_xfers"}, 32'(got_q.size()), 32'(exp_n));
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_bit_errors"}, 32'(mism), 32'd0);
    check({tag, "_pay_xfers"}, 32'(got_pay), aborted ? 32'(abort_at + 1) : 32'(len));
    check({tag, "_done_count"}, 32'(done_cnt), aborted ? 32'd0 : 32'd1);
    if (got_done) check({tag, "_drain_gap"}, 32'(gap), 32'(SPREAD));
    if (got_done && mode == 0 && st_len == 0)
      check({tag, "_latency"}, 32'(done_k), 32'(1 + PLEN + len + SPREAD));
    if (len == 0) check({tag, "_pay_ready_seen"}, 32'(saw_pay_ready), 32'd0);
    if (st_len > 0) check({tag, "_valid_in_stall"}, 32'(stall_viol), 32'd0);
    if (mode != 0) check({tag, "_hold_stable"}, 32'(stab_viol), 32'd0);
  endtask

  initial begin
    logic [15:0] lit;
    int          mism;
    i_reset = 1'b1; i_start = 1'b0; i_len = '0; i_abort = 1'b0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_valid", 32'(o_spr_valid), 32'd0);
    check("rst_data", 32'(o_spr_data), 32'd0);
    check("rst_pay_ready", 32'(o_pay_ready), 32'd0);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    // Nominal frame with payload 1,0,1,1
    pay_bits[0] = 1'b1; pay_bits[1] = 1'b0; pay_bits[2] = 1'b1; pay_bits[3] = 1'b1;
    run_frame(4, 0, -1, 0, -1, -1, 1'b0, "nominal");
    lit  = 16'b1010_0101_1111_0000;
    mism = 0;
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      if (got_q[i] !== lit[15-i]) mism++;
    check("nominal_preamble_literal", 32'(mism), 32'd0);

    // Spreader ready one cycle in 25
    run_frame(3, 1, -1, 0, -1, -1, 1'b1, "backpressure");

    // Zero-length payload with a second start during PRE
    run_frame(0, 0, -1, 0, -1, 5, 1'b1, "zero_len");

    // Upstream stall of 10 cycles after the second payload bit
    run_frame(5, 0, 2, 10, -1, -1, 1'b1, "stall");

    // Abort after 2 of 8 payload bits, then an immediate new frame
    run_frame(8, 0, -1, 0, 2, -1, 1'b1, "abort");
    run_frame(1, 0, -1, 0, -1, -1, 1'b1, "after_abort");

    // Asynchronous reset between edges during PRE
    ready_mode = 0; stall_at = -1; stall_len = 0; pay_len = 0;
    pay_start = pay_total; frame_id++;
    i_start = 1'b1; i_len = LEN_W'(6);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    check("prerst_valid", 32'(o_spr_valid), 32'd1);
    #2 i_reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(o_busy), 32'd0);
    check("async_rst_done", 32'(o_done), 32'd0);
    check("async_rst_valid", 32'(o_spr_valid), 32'd0);
    check("async_rst_data", 32'(o_spr_data), 32'd0);
    check("async_rst_pay_ready", 32'(o_pay_ready), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    frame_id++;
    repeat (20) @(negedge i_clk);
    check("post_rst_idle_busy", 32'(o_busy), 32'd0);
    check("post_rst_no_xfers", 32'(got_q.size()), 32'd0);
    check("post_rst_no_done", 32'(done_cnt), 32'd0);
    run_frame(2, 0, -1, 0, -1, -1, 1'b1, "post_rst_frame");

    // Randomized payloads under random spreader back-pressure
    for (int r = 0; r < 4; r++)
      run_frame(int'($urandom_range(1, 20)), 2, -1, 0, -1, -1, 1'b1, "random");

    // Maximum legal length must not wrap early
    run_frame(4095, 0, -1, 0, -1, -1, 1'b1, "max_len");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
